// File: rtl/match_uart_reporter.sv
// Counts match_pulse events, queues the low byte of each running count, and sends each queued byte as 8N1 UART on tx.
// tx falls one cycle after an event into an idle, empty queue; events arriving while the queue is full are dropped and flag overflow.
module match_uart_reporter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       match_pulse,
  output logic                       tx,
  output logic                       busy,
  output logic [CNT_W-1:0]           match_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;
  logic             pop;
  logic             push;
  logic             full, empty;
  logic             last_tick;
  logic [CNT_W-1:0] count_inc;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign full      = (fifo_level == LW'(DEPTH));
  assign empty     = (fifo_level == '0);
  assign count_inc = match_count + 1'b1;
  // A full queue still takes the event when the head leaves on the same edge.
  assign push      = match_pulse && (!full || pop);
  assign last_tick = (timer == TW'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= count_inc[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (match_pulse) match_count <= count_inc;
      if (match_pulse && full && !pop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (last_tick) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (last_tick) begin
          timer_n = '0;
          shift_n = shift >> 1;
          idx_n   = idx + 1'b1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (last_tick) begin
          timer_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is registered, so it is driven from the state being entered.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_match_uart_reporter.sv
// Directed bench: expected bytes queued at stimulus time, a UART receiver process decodes tx and scores each frame.
module tb_match_uart_reporter;

  localparam int C = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        match_pulse = 1'b0;
  logic        tx;
  logic        busy;
  logic [15:0] match_count;
  logic [2:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  int         fall_q [$];

  match_uart_reporter #(.CLKS_PER_BIT(C), .CNT_W(16), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .match_pulse(match_pulse), .tx(tx), .busy(busy),
    .match_count(match_count), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    match_pulse = 1'b1;
    step(n);
    match_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    exp_q.delete();
    fall_q.delete();
    rx_q.delete();
    rst = 1'b0;
  endtask

  // UART receiver / scoreboard monitor
  logic       prev_tx;
  logic       aborted, start_ok, stop_v;
  logic [7:0] rxb;
  initial begin
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) prev_tx = 1'b1;
      else if (prev_tx && !tx) begin
        fall_q.push_back(cyc);
        aborted = 1'b0; start_ok = 1'b1; stop_v = 1'b0; rxb = '0;
        for (int k = 1; k < 10*C; k++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (k == C-1 && tx !== 1'b0) start_ok = 1'b0;
          for (int i = 0; i < 8; i++) if (k == C*(1+i) + C/2) rxb[i] = tx;
          if (k == 9*C + C/2) stop_v = tx;
        end
        prev_tx = tx;
        if (!aborted) begin
          rx_q.push_back(rxb);
          chk("start_bit", start_ok, 1);
          chk("stop_bit", stop_v, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %02h expected no frame (cycle %0d)", rxb, cyc);
          end else begin
            chk("rx_byte", rxb, exp_q.pop_front());
          end
        end
      end else prev_tx = tx;
    end
  end

  int e, bad, peak;
  initial begin
    // 1: reset and idle
    step(3);
    chk("t1_rst_tx", tx, 1);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_count", match_count, 0);
    chk("t1_rst_level", fifo_level, 0);
    chk("t1_rst_ovf", overflow, 0);
    do_reset();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tx !== 1'b1 || busy !== 1'b0 || match_count != 0 || fifo_level != 0 || overflow !== 1'b0) bad++;
    end
    chk("t1_idle_hold", bad, 0);

    // 2: single pulse
    e = cyc + 1;
    exp_q.push_back(8'h01);
    pulse(1);
    chk("t2_count", match_count, 1);
    chk("t2_level_push", fifo_level, 1);
    step(1);
    chk("t2_tx_start", tx, 0);
    chk("t2_level_pop", fifo_level, 0);
    chk("t2_busy", busy, 1);
    step(3);
    chk("t2_tx_start_end", tx, 0);
    step(1);
    chk("t2_tx_bit0", tx, 1);
    step(4);
    chk("t2_tx_bit1", tx, 0);
    step(31);
    chk("t2_tx_stop", tx, 1);
    chk("t2_busy_e40", busy, 1);
    step(1);
    chk("t2_busy_e41", busy, 0);
    chk("t2_frames", fall_q.size(), 1);
    chk("t2_fall_cycle", (fall_q.size() > 0) ? fall_q[0] : -1, e + 1);

    // 3: three back-to-back pulses
    do_reset();
    step(5);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    peak = 0;
    match_pulse = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (fifo_level > peak) peak = fifo_level;
    end
    match_pulse = 1'b0;
    for (int i = 0; i < 130; i++) begin
      step(1);
      if (fifo_level > peak) peak = fifo_level;
    end
    chk("t3_peak_level", peak, 2);
    chk("t3_overflow", overflow, 0);
    chk("t3_count", match_count, 3);
    chk("t3_frames", fall_q.size(), 3);
    chk("t3_pitch01", (fall_q.size() > 2) ? fall_q[1] - fall_q[0] : -1, 41);
    chk("t3_pitch12", (fall_q.size() > 2) ? fall_q[2] - fall_q[1] : -1, 41);
    chk("t3_pending", exp_q.size(), 0);

    // 4: ten pulses, overflow
    do_reset();
    step(5);
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    pulse(10);
    chk("t4_count", match_count, 10);
    chk("t4_overflow", overflow, 1);
    chk("t4_level_full", fifo_level, 4);
    step(215);
    chk("t4_overflow_sticky", overflow, 1);
    chk("t4_frames", fall_q.size(), 5);
    chk("t4_pending", exp_q.size(), 0);
    chk("t4_busy_end", busy, 0);

    // 5: 300 spaced pulses, counter wrap of the low byte
    do_reset();
    step(5);
    for (int i = 1; i <= 300; i++) begin
      exp_q.push_back(8'(i & 255));
      pulse(1);
      step(49);
    end
    chk("t5_count", match_count, 300);
    chk("t5_frames", rx_q.size(), 300);
    chk("t5_byte256", (rx_q.size() > 255) ? rx_q[255] : -1, 8'h00);
    chk("t5_last_byte", (rx_q.size() > 299) ? rx_q[299] : -1, 8'h2C);
    chk("t5_overflow", overflow, 0);
    chk("t5_pending", exp_q.size(), 0);

    // 6: reset during data bit 3 with two entries queued
    do_reset();
    step(5);
    pulse(3);
    step(16);
    chk("t6_pre_tx", tx, 0);
    chk("t6_pre_level", fifo_level, 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_tx", tx, 1);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_count", match_count, 0);
    step(2);
    exp_q.delete();
    fall_q.delete();
    rx_q.delete();
    rst = 1'b0;
    step(100);
    chk("t6_no_frame", fall_q.size(), 0);
    chk("t6_tx_idle", tx, 1);
    chk("t6_level", fifo_level, 0);
    chk("t6_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
